// File: rtl/sym2_packer.sv
// Packs 2-bit symbols MSB-first into SYMS-symbol words and queues them in a
// first-word-fall-through FIFO; overflowing words are dropped and counted.
module sym2_packer #(
    parameter int SYMS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      in_vld,
    input  logic [1:0]                in_data,
    input  logic                      flush,
    output logic [2*SYMS-1:0]         out_data,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [$clog2(DEPTH):0]    fill_lvl,
    output logic [7:0]                drop_cnt,
    output logic                      ovf
);

    localparam int WORD_W = 2 * SYMS;
    localparam int CNT_W  = $clog2(SYMS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] word_w;
    logic              word_done;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;

    always_comb begin
        // Merge the symbol accepted this edge so a flush can include it.
        word_w = shreg_q;
        for (int unsigned i = 0; i < SYMS; i++) begin
            if (in_vld && (cnt_q == CNT_W'(i))) begin
                word_w[WORD_W-1-2*i -: 2] = in_data;
            end
        end

        word_done = in_vld && (cnt_q == CNT_W'(SYMS - 1));
        push      = word_done || (flush && ((cnt_q != '0) || in_vld));

        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (push) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (in_vld) begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = word_w;
        end

        pop   = (lvl_q != '0) && out_rdy;
        full  = (lvl_q == LVL_W'(DEPTH));
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = word_w;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        lvl_d = lvl_q;
        case ({wr_en, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase

        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= '0;
            shreg_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lvl_q      <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
        end
    end

    assign out_data = mem_q[rd_ptr_q];
    assign out_vld  = (lvl_q != '0);
    assign fill_lvl = lvl_q;
    assign drop_cnt = drop_cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_sym2_packer.sv
// Bench for sym2_packer: directed scenarios plus a long random run, all checked
// against a queue-based model of the packer and its FIFO.
module tb_sym2_packer;

    localparam int SYMS   = 4;
    localparam int DEPTH  = 4;
    localparam int WORD_W = 2 * SYMS;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              in_vld = 1'b0;
    logic [1:0]        in_data = '0;
    logic              flush = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [$clog2(DEPTH):0] fill_lvl;
    logic [7:0]        drop_cnt;
    logic              ovf;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [WORD_W-1:0] m_q[$];
    logic [WORD_W-1:0] m_word = '0;
    int                m_cnt  = 0;
    int                m_drops = 0;
    logic              m_ovf = 1'b0;

    sym2_packer #(.SYMS(SYMS), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .flush     (flush),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .fill_lvl  (fill_lvl),
        .drop_cnt  (drop_cnt),
        .ovf       (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_clear();
        m_q.delete();
        m_word  = '0;
        m_cnt   = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // Advance one clock: model the edge with the inputs currently driven, then
    // return at the falling edge where outputs are sampled and inputs changed.
    task automatic clk_step();
        int                pre_size;
        bit                do_pop;
        bit                do_push;
        logic [WORD_W-1:0] w;
        @(posedge sys_clk);
        if (sys_rst_n) begin
            pre_size = m_q.size();
            do_pop   = (pre_size > 0) && out_rdy;
            w        = m_word;
            if (in_vld) begin
                w = w | (WORD_W'(in_data) << (WORD_W - 2 - 2 * m_cnt));
                m_cnt++;
            end
            do_push = (m_cnt == SYMS) || (flush && (m_cnt > 0));
            if (do_push) begin
                m_cnt  = 0;
                m_word = '0;
            end else begin
                m_word = w;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (pre_size < DEPTH || do_pop) begin
                    m_q.push_back(w);
                end else begin
                    if (m_drops < 255) m_drops++;
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic drive(input bit v, input logic [1:0] d, input bit f, input bit r);
        in_vld  = v;
        in_data = d;
        flush   = f;
        out_rdy = r;
    endtask

    task automatic do_reset();
        drive(0, 2'd0, 0, 0);
        sys_rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_vld !== 1'b0 || out_data !== '0 || fill_lvl !== '0 ||
            drop_cnt !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: vld=%b data=%h lvl=%0d drop=%0d ovf=%b, want all zero",
                     out_vld, out_data, fill_lvl, drop_cnt, ovf);
        end
    endtask

    task automatic test_pack();
        logic [1:0] syms [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1, syms[i], 0, 1);
            clk_step();
            vectors++;
            if (out_vld !== (i == 3)) begin
                errors++;
                $display("FAIL pack_vld_timing: sym %0d vld=%b want %b", i, out_vld, (i == 3));
            end
        end
        vectors++;
        if (out_data !== 8'hE4 || fill_lvl !== 1) begin
            errors++;
            $display("FAIL pack_word: data=%h lvl=%0d want E4 lvl=1", out_data, fill_lvl);
        end
        drive(0, 2'd0, 0, 1);
        clk_step();
        vectors++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL pack_one_cycle: vld=%b want 0", out_vld);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            drive(1, 2'b01, 0, 0);
            clk_step();
        end
        vectors++;
        if (fill_lvl !== 4 || drop_cnt !== 8'd1 || ovf !== 1'b1 || out_data !== 8'h55) begin
            errors++;
            $display("FAIL overflow_drop: lvl=%0d drop=%0d ovf=%b data=%h want 4 1 1 55",
                     fill_lvl, drop_cnt, ovf, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'd0, 0, 1);
            vectors++;
            if (out_vld !== 1'b1 || out_data !== 8'h55) begin
                errors++;
                $display("FAIL overflow_drain: word %0d vld=%b data=%h want 1 55", i, out_vld, out_data);
            end
            clk_step();
        end
        vectors++;
        if (out_vld !== 1'b0 || fill_lvl !== 0) begin
            errors++;
            $display("FAIL overflow_empty: vld=%b lvl=%0d want 0 0", out_vld, fill_lvl);
        end
    endtask

    task automatic test_flush();
        logic [WORD_W-1:0] want [3] = '{8'hB4, 8'hFF, 8'h55};
        drive(1, 2'd2, 0, 0); clk_step();
        drive(1, 2'd3, 0, 0); clk_step();
        drive(1, 2'd1, 1, 0); clk_step();
        vectors++;
        if (fill_lvl !== 1 || out_data !== 8'hB4) begin
            errors++;
            $display("FAIL flush_partial: lvl=%0d data=%h want 1 B4", fill_lvl, out_data);
        end
        drive(0, 2'd0, 1, 0); clk_step();
        vectors++;
        if (fill_lvl !== 1) begin
            errors++;
            $display("FAIL flush_empty: lvl=%0d want 1", fill_lvl);
        end
        // Counter must be back at 0: four 3s form a clean FF word
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd3, 0, 0); clk_step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd1, (i == 3), 0); clk_step();
        end
        vectors++;
        if (fill_lvl !== 3) begin
            errors++;
            $display("FAIL flush_on_complete: lvl=%0d want 3", fill_lvl);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 0, 1);
            vectors++;
            if (out_vld !== 1'b1 || out_data !== want[i]) begin
                errors++;
                $display("FAIL flush_order: word %0d data=%h want %h", i, out_data, want[i]);
            end
            clk_step();
        end
    endtask

    task automatic test_full_pop();
        int drops_before;
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'($urandom_range(0, 3)), 0, 0); clk_step();
        end
        drops_before = m_drops;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'($urandom_range(0, 3)), 0, 0); clk_step();
        end
        drive(1, 2'($urandom_range(0, 3)), 0, 1); clk_step();
        vectors++;
        if (fill_lvl !== 4 || drop_cnt !== 8'(drops_before) || m_q.size() != 4) begin
            errors++;
            $display("FAIL full_with_pop: lvl=%0d drop=%0d want 4 %0d", fill_lvl, drop_cnt, drops_before);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'd0, 0, 1);
            vectors++;
            if (out_vld !== 1'b1 || out_data !== m_q[0]) begin
                errors++;
                $display("FAIL full_pop_order: word %0d data=%h want %h", i, out_data, m_q[0]);
            end
            clk_step();
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] syms [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'd2, 0, 0); clk_step();
        end
        #2;
        sys_rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (out_vld !== 1'b0 || fill_lvl !== 0 || drop_cnt !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: vld=%b lvl=%0d drop=%0d ovf=%b want 0 0 0 0",
                     out_vld, fill_lvl, drop_cnt, ovf);
        end
        drive(0, 2'd0, 0, 1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, syms[i], 0, 1); clk_step();
        end
        vectors++;
        if (out_vld !== 1'b1 || out_data !== 8'h03 || fill_lvl !== 1) begin
            errors++;
            $display("FAIL reset_partial_gone: vld=%b data=%h lvl=%0d want 1 03 1",
                     out_vld, out_data, fill_lvl);
        end
        drive(0, 2'd0, 0, 1); clk_step();
    endtask

    task automatic test_random();
        int rdy_pct;
        for (int c = 0; c < 10000; c++) begin
            rdy_pct = (c < 4000) ? 10 : 60;
            drive(($urandom_range(0, 99) < 85), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < rdy_pct));
            clk_step();
            vectors++;
            if (out_vld !== (m_q.size() != 0) || fill_lvl !== m_q.size() ||
                drop_cnt !== 8'(m_drops) || ovf !== m_ovf ||
                (m_q.size() != 0 && out_data !== m_q[0])) begin
                errors++;
                $display("FAIL random_cycle %0d: vld=%b lvl=%0d drop=%0d ovf=%b data=%h want lvl=%0d drop=%0d ovf=%b data=%h",
                         c, out_vld, fill_lvl, drop_cnt, ovf, out_data, m_q.size(), m_drops, m_ovf,
                         (m_q.size() != 0) ? m_q[0] : '0);
            end
        end
        vectors++;
        if (drop_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d want 255", drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_overflow();
        test_flush();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
